// File: rtl/dbg_system_interface.sv
// Host-side root of the debug ring: host word stream <-> DI packets, plus the subnet control module (SCM).
// Latency: host word -> ring FIFO output 1 cycle; SCM response queued 1 cycle after the request's last flit.
// Backpressure: glip_in_ready follows the selected sink (ring FIFO / SCM); ring_in_ready[0] drops while a buffered packet drains.
//
// Ports: clk/rst (async active-high); glip_in_* host->chip words; glip_out_* chip->host words;
//        ring_out_* / ring_in_* two-channel ring (only channel 0 carries traffic); sys_rst/cpu_rst reset outputs.

module dbg_fifo #(
    parameter int WIDTH = 17,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_vld,
    input  logic [WIDTH-1:0] in_dat,
    output logic             in_rdy,
    output logic             out_vld,
    output logic [WIDTH-1:0] out_dat,
    input  logic             out_rdy
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             push;
    logic             pop;

    assign out_vld = (count != '0);
    assign out_dat = mem[rd_ptr];
    // A full FIFO still accepts when the head leaves in the same cycle.
    assign in_rdy  = (count != FULL_CNT) | out_rdy;
    assign push    = in_vld & in_rdy;
    assign pop     = out_vld & out_rdy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= in_dat;
    end
endmodule

module dbg_system_interface #(
    parameter int SYSTEM_VENDOR_ID         = 2,
    parameter int SYSTEM_DEVICE_ID         = 1,
    parameter int NUM_MODULES              = 1,
    parameter int SUBNET_BITS              = 6,
    parameter int LOCAL_SUBNET             = 0,
    parameter int MAX_PKT_LEN              = 12,
    parameter int DEBUG_ROUTER_BUFFER_SIZE = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] glip_in_data,
    input  logic        glip_in_valid,
    output logic        glip_in_ready,
    output logic [15:0] glip_out_data,
    output logic        glip_out_valid,
    input  logic        glip_out_ready,
    output logic [31:0] ring_out_data,
    output logic [1:0]  ring_out_last,
    output logic [1:0]  ring_out_valid,
    input  logic [1:0]  ring_out_ready,
    input  logic [31:0] ring_in_data,
    input  logic [1:0]  ring_in_last,
    input  logic [1:0]  ring_in_valid,
    output logic [1:0]  ring_in_ready,
    output logic        sys_rst,
    output logic        cpu_rst
);
    localparam logic [15:0] SCM_ID      = 16'(LOCAL_SUBNET << (16 - SUBNET_BITS));
    localparam int          CW          = $clog2(MAX_PKT_LEN + 1);
    localparam logic [CW-1:0] MAX_CNT   = CW'(MAX_PKT_LEN);
    localparam logic [15:0] ADDR_SYSRST = 16'h0204;
    localparam logic [3:0]  SUB_RD      = 4'b0000;
    localparam logic [3:0]  SUB_WR      = 4'b0001;
    localparam logic [3:0]  RSP_RD_OK   = 4'b1000;
    localparam logic [3:0]  RSP_RD_ERR  = 4'b1001;
    localparam logic [3:0]  RSP_WR_OK   = 4'b1010;
    localparam logic [3:0]  RSP_WR_ERR  = 4'b1011;

    // ---------------- ingress: host words -> ring FIFO / SCM ----------------
    typedef enum logic [1:0] {IN_LEN, IN_HDR, IN_FWD, IN_SCM} in_state_t;
    in_state_t   in_state, in_state_nxt;
    logic [15:0] in_remain, in_remain_nxt;
    logic        in_rdy, in_last;
    logic        fifo_push, scm_push;
    logic        fifo_in_rdy, fifo_out_vld;
    logic [16:0] fifo_out_dat;
    logic        scm_free;

    always_comb begin
        in_state_nxt  = in_state;
        in_remain_nxt = in_remain;
        in_rdy        = 1'b0;
        fifo_push     = 1'b0;
        scm_push      = 1'b0;
        in_last       = (in_remain == 16'd1);
        case (in_state)
            IN_LEN: begin
                in_rdy = 1'b1;
                if (glip_in_valid && glip_in_data != 16'd0) begin
                    in_remain_nxt = glip_in_data;
                    in_state_nxt  = IN_HDR;
                end
            end
            IN_HDR: begin
                // The destination flit itself selects the sink, so ready depends on the data.
                if (glip_in_data == SCM_ID) begin
                    in_rdy   = scm_free;
                    scm_push = glip_in_valid & scm_free;
                end else begin
                    in_rdy    = fifo_in_rdy;
                    fifo_push = glip_in_valid & fifo_in_rdy;
                end
            end
            IN_FWD: begin
                in_rdy    = fifo_in_rdy;
                fifo_push = glip_in_valid & fifo_in_rdy;
            end
            IN_SCM: begin
                in_rdy   = scm_free;
                scm_push = glip_in_valid & scm_free;
            end
            default: in_state_nxt = IN_LEN;
        endcase
        if (fifo_push || scm_push) begin
            in_remain_nxt = in_remain - 16'd1;
            if (in_last)       in_state_nxt = IN_LEN;
            else if (scm_push) in_state_nxt = IN_SCM;
            else               in_state_nxt = IN_FWD;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_state  <= IN_LEN;
            in_remain <= '0;
        end else begin
            in_state  <= in_state_nxt;
            in_remain <= in_remain_nxt;
        end
    end

    assign glip_in_ready = in_rdy & ~rst;

    dbg_fifo #(.WIDTH(17), .DEPTH(DEBUG_ROUTER_BUFFER_SIZE)) u_ring_out_fifo (
        .clk     (clk),
        .rst     (rst),
        .in_vld  (fifo_push),
        .in_dat  ({in_last, glip_in_data}),
        .in_rdy  (fifo_in_rdy),
        .out_vld (fifo_out_vld),
        .out_dat (fifo_out_dat),
        .out_rdy (ring_out_ready[0])
    );

    assign ring_out_data  = {16'h0000, fifo_out_dat[15:0]};
    assign ring_out_last  = {1'b0, fifo_out_dat[16]};
    assign ring_out_valid = {1'b0, fifo_out_vld};

    // ---------------- SCM ----------------
    logic [2:0]  req_cnt;    // flits seen in current request, saturating at 5
    logic [15:0] req_src, req_addr;
    logic [1:0]  req_type;
    logic [3:0]  req_sub;
    logic        req_proc;   // request complete, evaluate this cycle
    logic        resp_vld, resp_long, resp_done;
    logic [15:0] resp_dest, resp_flags, resp_data;
    logic [1:0]  sysrst;
    logic        rd_ok;
    logic [15:0] rd_val;

    // Busy from the last request flit until its response has left the egress.
    assign scm_free = ~req_proc & ~resp_vld;

    always_comb begin
        rd_ok  = 1'b1;
        rd_val = 16'h0000;
        case (req_addr)
            16'h0000:    rd_val = 16'h0001;
            16'h0001:    rd_val = 16'h0001;
            16'h0002:    rd_val = 16'h0000;
            16'h0200:    rd_val = 16'(SYSTEM_VENDOR_ID);
            16'h0201:    rd_val = 16'(SYSTEM_DEVICE_ID);
            16'h0202:    rd_val = 16'(NUM_MODULES);
            16'h0203:    rd_val = 16'(MAX_PKT_LEN);
            ADDR_SYSRST: rd_val = {14'd0, sysrst};
            default:     rd_ok  = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_cnt    <= '0;
            req_src    <= '0;
            req_type   <= '0;
            req_sub    <= '0;
            req_addr   <= '0;
            req_proc   <= 1'b0;
            resp_vld   <= 1'b0;
            resp_long  <= 1'b0;
            resp_dest  <= '0;
            resp_flags <= '0;
            resp_data  <= '0;
            sysrst     <= '0;
        end else begin
            if (scm_push) begin
                if (req_cnt != 3'd5) req_cnt <= req_cnt + 3'd1;
                case (req_cnt)
                    3'd1: req_src <= glip_in_data;
                    3'd2: begin
                        req_type <= glip_in_data[15:14];
                        req_sub  <= glip_in_data[13:10];
                    end
                    3'd3: req_addr <= glip_in_data;
                    // The write lands as soon as the wdata flit is taken, not when the response is built.
                    3'd4: if (req_type == 2'b00 && req_sub == SUB_WR && req_addr == ADDR_SYSRST)
                              sysrst <= glip_in_data[1:0];
                    default: ;
                endcase
                if (in_last) req_proc <= 1'b1;
            end
            if (req_proc) begin
                req_proc <= 1'b0;
                req_cnt  <= '0;
                // Unknown type/subtype or a packet too short to carry flags: silently dropped.
                if (req_cnt >= 3'd3 && req_type == 2'b00 && (req_sub == SUB_RD || req_sub == SUB_WR)) begin
                    resp_vld  <= 1'b1;
                    resp_dest <= req_src;
                    resp_data <= rd_val;
                    resp_long <= 1'b0;
                    if (req_sub == SUB_RD) begin
                        if (req_cnt >= 3'd4 && rd_ok) begin
                            resp_flags <= {2'b00, RSP_RD_OK, 10'd0};
                            resp_long  <= 1'b1;
                        end else begin
                            resp_flags <= {2'b00, RSP_RD_ERR, 10'd0};
                        end
                    end else if (req_cnt == 3'd5 && req_addr == ADDR_SYSRST) begin
                        resp_flags <= {2'b00, RSP_WR_OK, 10'd0};
                    end else begin
                        resp_flags <= {2'b00, RSP_WR_ERR, 10'd0};
                    end
                end
            end
            if (resp_done) resp_vld <= 1'b0;
        end
    end

    assign sys_rst = rst | sysrst[0];
    assign cpu_rst = rst | sysrst[0] | sysrst[1];

    // ---------------- ring ingress packet buffer ----------------
    logic [15:0]   rb_mem [MAX_PKT_LEN];
    logic [CW-1:0] rb_cnt;
    logic          rb_done;  // complete packet held, waiting to drain
    logic          rb_push, ring_drained;

    assign rb_push       = ring_in_valid[0] & ~rb_done;
    assign ring_in_ready = {1'b1, ~rb_done};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rb_cnt  <= '0;
            rb_done <= 1'b0;
        end else begin
            if (rb_push) begin
                if (rb_cnt != MAX_CNT) rb_cnt <= rb_cnt + CW'(1);
                if (ring_in_last[0])   rb_done <= 1'b1;
            end
            if (ring_drained) begin
                rb_cnt  <= '0;
                rb_done <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rb_push && rb_cnt != MAX_CNT) rb_mem[rb_cnt] <= ring_in_data[15:0];
    end

    // ---------------- egress arbiter: whole packets, SCM first ----------------
    typedef enum logic [1:0] {EG_IDLE, EG_SCM, EG_RING} eg_state_t;
    eg_state_t     eg_state, eg_state_nxt;
    logic [CW-1:0] eg_idx, eg_idx_nxt;  // 0 = length word, k = flit k
    logic [CW-1:0] eg_len;
    logic          eg_last;

    always_comb begin
        eg_state_nxt   = eg_state;
        eg_idx_nxt     = eg_idx;
        eg_len         = resp_long ? CW'(4) : CW'(3);
        if (eg_state == EG_RING) eg_len = rb_cnt;
        eg_last        = (eg_idx == eg_len);
        glip_out_valid = (eg_state != EG_IDLE);
        glip_out_data  = 16'(eg_len);
        resp_done      = 1'b0;
        ring_drained   = 1'b0;
        if (eg_idx != '0) begin
            if (eg_state == EG_RING) begin
                glip_out_data = rb_mem[eg_idx - CW'(1)];
            end else begin
                case (eg_idx)
                    CW'(1):  glip_out_data = resp_dest;
                    CW'(2):  glip_out_data = SCM_ID;
                    CW'(3):  glip_out_data = resp_flags;
                    default: glip_out_data = resp_data;
                endcase
            end
        end
        case (eg_state)
            EG_IDLE: begin
                eg_idx_nxt = '0;
                if (resp_vld)     eg_state_nxt = EG_SCM;
                else if (rb_done) eg_state_nxt = EG_RING;
            end
            default: begin
                if (glip_out_ready) begin
                    if (eg_last) begin
                        eg_state_nxt = EG_IDLE;
                        eg_idx_nxt   = '0;
                        resp_done    = (eg_state == EG_SCM);
                        ring_drained = (eg_state == EG_RING);
                    end else begin
                        eg_idx_nxt = eg_idx + CW'(1);
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            eg_state <= EG_IDLE;
            eg_idx   <= '0;
        end else begin
            eg_state <= eg_state_nxt;
            eg_idx   <= eg_idx_nxt;
        end
    end

    // Channel 1 is tied off; its inputs are intentionally ignored.
    logic unused_ch1;
    assign unused_ch1 = ^{ring_in_data[31:16], ring_in_last[1], ring_in_valid[1], ring_out_ready[1]};
endmodule

// File: tb/tb_dbg_system_interface.sv
module tb_dbg_system_interface;
    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] glip_in_data;
    logic        glip_in_valid;
    logic        glip_in_ready;
    logic [15:0] glip_out_data;
    logic        glip_out_valid;
    logic        glip_out_ready;
    logic [31:0] ring_out_data;
    logic [1:0]  ring_out_last;
    logic [1:0]  ring_out_valid;
    logic [1:0]  ring_out_ready;
    logic [31:0] ring_in_data;
    logic [1:0]  ring_in_last;
    logic [1:0]  ring_in_valid;
    logic [1:0]  ring_in_ready;
    logic        sys_rst;
    logic        cpu_rst;

    always #5 clk = ~clk;

    dbg_system_interface dut (
        .clk            (clk),
        .rst            (rst),
        .glip_in_data   (glip_in_data),
        .glip_in_valid  (glip_in_valid),
        .glip_in_ready  (glip_in_ready),
        .glip_out_data  (glip_out_data),
        .glip_out_valid (glip_out_valid),
        .glip_out_ready (glip_out_ready),
        .ring_out_data  (ring_out_data),
        .ring_out_last  (ring_out_last),
        .ring_out_valid (ring_out_valid),
        .ring_out_ready (ring_out_ready),
        .ring_in_data   (ring_in_data),
        .ring_in_last   (ring_in_last),
        .ring_in_valid  (ring_in_valid),
        .ring_in_ready  (ring_in_ready),
        .sys_rst        (sys_rst),
        .cpu_rst        (cpu_rst)
    );

    int n_checks = 0;
    int n_fail   = 0;
    logic [15:0] out_q[$];
    logic [15:0] exp_q[$];
    logic [16:0] ring_q[$];
    logic [16:0] rexp_q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Transfers happen at the posedge following this sample point; inputs only move on negedges.
    always @(negedge clk) begin
        #1;
        if (glip_out_valid && glip_out_ready) out_q.push_back(glip_out_data);
        if (ring_out_valid[0] && ring_out_ready[0]) ring_q.push_back({ring_out_last[0], ring_out_data[15:0]});
    end

    task automatic ex(input logic [15:0] w);
        exp_q.push_back(w);
    endtask

    task automatic rex(input logic last, input logic [15:0] w);
        rexp_q.push_back({last, w});
    endtask

    task automatic host_send(input logic [15:0] w);
        int t;
        t = 0;
        glip_in_data  = w;
        glip_in_valid = 1'b1;
        #1;
        while (!glip_in_ready && t < 200) begin
            @(negedge clk);
            #1;
            t++;
        end
        if (!glip_in_ready) chk("host_send_timeout", 32'(glip_in_ready), 32'd1);
        @(negedge clk);
        glip_in_valid = 1'b0;
    endtask

    task automatic ring_send(input logic [15:0] w, input logic last);
        int t;
        t = 0;
        ring_in_data  = {16'h0000, w};
        ring_in_last  = {1'b0, last};
        ring_in_valid = 2'b01;
        #1;
        while (!ring_in_ready[0] && t < 200) begin
            @(negedge clk);
            #1;
            t++;
        end
        if (!ring_in_ready[0]) chk("ring_send_timeout", 32'(ring_in_ready[0]), 32'd1);
        @(negedge clk);
        ring_in_valid = 2'b00;
        ring_in_last  = 2'b00;
    endtask

    task automatic scm_read(input logic [15:0] addr);
        host_send(16'h0004); host_send(16'h0000); host_send(16'h0400);
        host_send(16'h0000); host_send(addr);
    endtask

    task automatic scm_write(input logic [15:0] addr, input logic [15:0] data);
        host_send(16'h0005); host_send(16'h0000); host_send(16'h0400);
        host_send(16'h0400); host_send(addr); host_send(data);
    endtask

    task automatic check_glip(input string tag);
        int t;
        t = 0;
        while (out_q.size() < exp_q.size() && t < 300) begin
            @(negedge clk);
            t++;
        end
        @(negedge clk);
        #2;
        chk({tag, "_cnt"}, 32'(out_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < out_q.size(); i++)
            chk($sformatf("%s_w%0d", tag, i), 32'(out_q[i]), 32'(exp_q[i]));
        out_q.delete();
        exp_q.delete();
    endtask

    task automatic check_ring(input string tag);
        int t;
        t = 0;
        while (ring_q.size() < rexp_q.size() && t < 300) begin
            @(negedge clk);
            t++;
        end
        @(negedge clk);
        #2;
        chk({tag, "_cnt"}, 32'(ring_q.size()), 32'(rexp_q.size()));
        for (int i = 0; i < rexp_q.size() && i < ring_q.size(); i++)
            chk($sformatf("%s_f%0d", tag, i), 32'(ring_q[i]), 32'(rexp_q[i]));
        ring_q.delete();
        rexp_q.delete();
    endtask

    initial begin
        rst            = 1'b1;
        glip_in_data   = '0;
        glip_in_valid  = 1'b0;
        glip_out_ready = 1'b1;
        ring_out_ready = 2'b01;
        ring_in_data   = '0;
        ring_in_last   = '0;
        ring_in_valid  = '0;

        // reset state
        repeat (3) @(negedge clk);
        #1;
        chk("rst_sys_rst", 32'(sys_rst), 32'd1);
        chk("rst_cpu_rst", 32'(cpu_rst), 32'd1);
        chk("rst_glip_out_valid", 32'(glip_out_valid), 32'd0);
        chk("rst_ring_out_valid", 32'(ring_out_valid), 32'd0);
        chk("rst_glip_in_ready", 32'(glip_in_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_sys_rst", 32'(sys_rst), 32'd0);
        chk("post_cpu_rst", 32'(cpu_rst), 32'd0);
        chk("post_glip_out_valid", 32'(glip_out_valid), 32'd0);
        chk("post_ring_out_valid", 32'(ring_out_valid), 32'd0);
        chk("post_ring_in_ready", 32'(ring_in_ready), 32'd3);
        chk("post_glip_in_ready", 32'(glip_in_ready), 32'd1);
        @(negedge clk);

        // read vendor id
        scm_read(16'h0200);
        ex(16'h0004); ex(16'h0400); ex(16'h0000); ex(16'h2000); ex(16'h0002);
        check_glip("rd_vendor");

        // SYSRST writes
        scm_write(16'h0204, 16'h0002);
        ex(16'h0003); ex(16'h0400); ex(16'h0000); ex(16'h2800);
        check_glip("wr_sysrst2");
        chk("wr2_cpu_rst", 32'(cpu_rst), 32'd1);
        chk("wr2_sys_rst", 32'(sys_rst), 32'd0);
        scm_read(16'h0204);
        ex(16'h0004); ex(16'h0400); ex(16'h0000); ex(16'h2000); ex(16'h0002);
        check_glip("rd_sysrst");
        scm_write(16'h0204, 16'h0001);
        ex(16'h0003); ex(16'h0400); ex(16'h0000); ex(16'h2800);
        check_glip("wr_sysrst1");
        chk("wr1_cpu_rst", 32'(cpu_rst), 32'd1);
        chk("wr1_sys_rst", 32'(sys_rst), 32'd1);
        scm_write(16'h0204, 16'h0000);
        ex(16'h0003); ex(16'h0400); ex(16'h0000); ex(16'h2800);
        check_glip("wr_sysrst0");
        chk("wr0_cpu_rst", 32'(cpu_rst), 32'd0);
        chk("wr0_sys_rst", 32'(sys_rst), 32'd0);

        // error responses
        scm_read(16'h0300);
        ex(16'h0003); ex(16'h0400); ex(16'h0000); ex(16'h2400);
        check_glip("rd_err");
        scm_write(16'h0000, 16'h1234);
        ex(16'h0003); ex(16'h0400); ex(16'h0000); ex(16'h2C00);
        check_glip("wr_ro_err");

        // forward to ring, zero-length word ignored first
        host_send(16'h0000);
        host_send(16'h0003); host_send(16'h0001); host_send(16'h0400); host_send(16'h4000);
        rex(1'b0, 16'h0001); rex(1'b0, 16'h0400); rex(1'b1, 16'h4000);
        check_ring("fwd");

        // ring FIFO backpressure
        ring_out_ready = 2'b00;
        host_send(16'h0003); host_send(16'h0001); host_send(16'h0400); host_send(16'h4000);
        host_send(16'h0003); host_send(16'h0005);
        glip_in_data  = 16'h0006;
        glip_in_valid = 1'b1;
        #1;
        chk("stall_rdy_a", 32'(glip_in_ready), 32'd0);
        repeat (3) @(negedge clk);
        #1;
        chk("stall_rdy_b", 32'(glip_in_ready), 32'd0);
        chk("stall_ring_valid", 32'(ring_out_valid), 32'd1);
        @(negedge clk);
        ring_out_ready = 2'b01;
        host_send(16'h0006);
        host_send(16'h0007);
        rex(1'b0, 16'h0001); rex(1'b0, 16'h0400); rex(1'b1, 16'h4000);
        rex(1'b0, 16'h0005); rex(1'b0, 16'h0006); rex(1'b1, 16'h0007);
        check_ring("stall");

        // ring -> host
        ring_send(16'h0400, 1'b0); ring_send(16'h0001, 1'b0);
        ring_send(16'h4000, 1'b0); ring_send(16'hBEEF, 1'b1);
        ex(16'h0004); ex(16'h0400); ex(16'h0001); ex(16'h4000); ex(16'hBEEF);
        check_glip("ring_in4");

        // oversize ring packet truncated to 12 flits
        for (int i = 0; i < 14; i++) ring_send(16'h1000 + 16'(i), (i == 13));
        ex(16'h000C);
        for (int i = 0; i < 12; i++) ex(16'h1000 + 16'(i));
        check_glip("ring_in14");

        // SCM response pending while a ring packet holds the egress
        glip_out_ready = 1'b0;
        ring_send(16'hA001, 1'b0);
        ring_send(16'hA002, 1'b1);
        repeat (2) @(negedge clk);
        #1;
        chk("drain_ring_in_ready", 32'(ring_in_ready), 32'd2);
        chk("drain_out_valid", 32'(glip_out_valid), 32'd1);
        @(negedge clk);
        scm_read(16'h0200);
        repeat (3) @(negedge clk);
        glip_out_ready = 1'b1;
        ex(16'h0002); ex(16'hA001); ex(16'hA002);
        ex(16'h0004); ex(16'h0400); ex(16'h0000); ex(16'h2000); ex(16'h0002);
        check_glip("arb");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
